uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//   Asynchronous serial receiver; the far-end counterpart of uart_tx on the same link.
//   Samples rx at 16x oversampling, deframes start/data/parity/stop and presents each word
//   with a one-cycle valid strobe plus parity and framing error flags.
//   Self-contained: generates its own oversample tick.
// PARAMETERS
//   CLK_FREQ    50_000_000  system clock frequency in Hz
//   BAUD_RATE   9600        line rate in bit/s
//   PARITY_BIT  0           0 = none, 1 = odd, 2 = even
//   DATA_LEN    8           data bits per frame, 5..9, LSB received first
//   STOP_BIT    1           1 = one stop bit, 2 = two, 3 = 1.5
// PORTS
//   clk         in   1         system clock
//   rst         in   1         asynchronous, active-low reset
//   rx          in   1         serial line; idles high; asynchronous to clk
//   data_out    out  DATA_LEN  last received word; held until the next data_valid
//   data_valid  out  1         single-cycle pulse when a frame completes
//   parity_err  out  1         parity mismatch in the last frame (0 when PARITY_BIT=0)
//   frame_err   out  1         a sampled stop bit was 0 in the last frame
//   busy        out  1         high from start-bit detection until the frame ends
// BEHAVIOUR
//   Reset (rst=0, async)
//     - data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0.
//     - FSM goes to IDLE; synchroniser flops are set to 1; all counters are cleared.
//     - Applies from any state; the partial frame is discarded with no data_valid.
//   Input synchroniser
//     - rx passes through a 2-flop synchroniser before any use.
//   Oversample tick
//     - OS_DIV = CLK_FREQ/(BAUD_RATE*16), integer-truncated.
//     - tick is a one-cycle pulse every OS_DIV clocks.
//     - The divider is restarted on start-edge detection, so the phase is aligned per frame.
//   FSM states: IDLE, START, DATA, PARITY, STOP.
//   IDLE
//     - A 1->0 transition on synced rx enters START, sets busy=1 and clears the tick count.
//   START
//     - At tick 8, synced rx is sampled.
//     - If 1: false start; go to IDLE, busy=0, no data_valid.
//     - If 0: go to DATA and reset the tick count.
//   DATA
//     - One sample every 16 ticks, at mid-bit, shifted in LSB first.
//     - After DATA_LEN samples: go to PARITY if PARITY_BIT!=0, else to STOP.
//   PARITY
//     - One mid-bit sample.
//     - Odd: error if ^{data,p} != 1. Even: error if ^{data,p} != 0.
//   STOP
//     - STOP_BIT=1 or 3: one mid-bit sample. STOP_BIT=2: two samples, 16 ticks apart.
//     - Any sampled 0 sets the frame error.
//     - After the last stop sample: go to IDLE, busy=0.
//     - Returning to IDLE at mid-stop lets a back-to-back start edge be caught.
//   Output update
//     - On the clock after the last stop sample: data_valid=1 for exactly one cycle.
//     - data_out, parity_err and frame_err update in that same cycle and hold until the next data_valid.
//     - data_valid asserts even when frame_err or parity_err is set.
//   Line held low
//     - A frame with frame_err returns to IDLE.
//     - A new frame needs a 1->0 edge, so a continuously low line yields exactly one frame.
// CONFIGURATION
//   UART_RX_MAJORITY_EN
//     - Defined: each bit value (start, data, parity, stop) is the 2-of-3 majority of
//       synced rx at ticks 7, 8 and 9. Single-sample glitches are rejected.
//     - Undefined: single sample at tick 8 only.
//     - Ports and timing are identical in both builds.
// TESTING
//   Bench setup: CLK_FREQ=1_536_000, BAUD_RATE=9600, giving OS_DIV=10 and 160 clk per bit.
//   1. 8N1, send 0xA5 -> one data_valid pulse, data_out=0xA5, parity_err=0, frame_err=0, busy low after.
//   2. PARITY_BIT=2, send 0x3C with parity bit=1 -> data_valid, data_out=0x3C, parity_err=1;
//      then send 0x3C with parity bit=0 -> parity_err=0.
//   3. Send 0x81 with stop bit driven 0 -> data_valid, frame_err=1; 1 bit idle,
//      then 0x55 clean -> frame_err=0, data_out=0x55.
//   4. Drive rx low for 40 clk, then high -> busy pulses, then clears; no data_valid; a following 0x12 is received correctly.
//   5. Assert rst during data bit 4 of 0xF0 -> all outputs 0 immediately; after release, 0x0F received correctly.
//   6. STOP_BIT=2, frames 0x00 then 0xFF back-to-back with no gap -> two data_valid pulses
//      320*(1+8+2)/2 clk apart, both error-free.
//      With UART_RX_MAJORITY_EN: a 1-clk high glitch at tick 8 of bit 0 of 0x00 -> data_out=0x00.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx - 16x oversampled asynchronous serial receiver.
//   Synchronises rx, aligns an oversample divider to each start edge and
//   deframes start/data/parity/stop. Each completed word is presented with a
//   one-cycle data_valid strobe. The parity and framing error flags are held
//   with the word until the next data_valid.
// Ports:
//   clk         system clock
//   rst         asynchronous, active-low reset
//   rx          serial line, idles high, asynchronous to clk
//   data_out    last received word (LSB received first)
//   data_valid  one-cycle pulse when a frame completes
//   parity_err  parity mismatch in the last frame (0 when PARITY_BIT=0)
//   frame_err   a sampled stop bit was 0 in the last frame
//   busy        high from start-edge detection until the frame ends
// Configuration:
//   UART_RX_MAJORITY_EN  when defined, every bit is the 2-of-3 majority of the
//                        samples at ticks 7, 8 and 9. When undefined, the bit
//                        is the single sample taken at tick 8.
module uart_rx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int PARITY_BIT = 0,
  parameter int DATA_LEN   = 8,
  parameter int STOP_BIT   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx,
  output logic [DATA_LEN-1:0] data_out,
  output logic                data_valid,
  output logic                parity_err,
  output logic                frame_err,
  output logic                busy
);

  localparam int OS_DIV = CLK_FREQ / (BAUD_RATE * 16);
  localparam int DIV_W  = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(OS_DIV - 1);
  localparam logic [3:0]       LAST_DATA = 4'(DATA_LEN - 1);
  localparam logic [3:0]       LAST_STOP = (STOP_BIT == 2) ? 4'd1 : 4'd0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

`ifdef UART_RX_MAJORITY_EN
  function automatic logic maj3_f(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
`endif

  // Parity check over the received word plus the received parity bit.
  function automatic logic par_bad_f(input logic [DATA_LEN-1:0] d, input logic p);
    logic x;
    x = ^{d, p};
    if (PARITY_BIT == 1) begin
      return (x != 1'b1);
    end else if (PARITY_BIT == 2) begin
      return (x != 1'b0);
    end else begin
      return 1'b0;
    end
  endfunction

  logic             rx_meta_r, rx_sync_r, rx_prev_r;
  logic [DIV_W-1:0] div_cnt_r;
  logic [3:0]       tick_cnt_r;
  logic             samp8_r;
`ifdef UART_RX_MAJORITY_EN
  logic             samp7_r;
`endif
  logic             tick_s, decide_s, bit_s, start_edge_s, frame_done_s;
  state_t           state_r, next_state_s;
  logic [3:0]       bit_cnt_r;
  logic [DATA_LEN-1:0] shift_r;
  logic             par_bad_r, stop_bad_r;

  assign start_edge_s = (state_r == IDLE) && rx_prev_r && !rx_sync_r;
  assign tick_s       = (state_r != IDLE) && (div_cnt_r == DIV_LAST);
  // tick_cnt_r counts ticks from the bit boundary; the bit is resolved one tick
  // after mid-bit so both builds have identical timing and the majority build
  // already holds its third sample.
  assign decide_s     = tick_s && (tick_cnt_r == 4'd8);
`ifdef UART_RX_MAJORITY_EN
  assign bit_s = maj3_f(samp7_r, samp8_r, rx_sync_r);
`else
  assign bit_s = samp8_r;
`endif

  // Two-flop synchroniser plus one delayed copy used for falling-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Oversample divider and tick counter; both are held at zero while idle, so a
  // start edge restarts them in phase with the new frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_r  <= {DIV_W{1'b0}};
      tick_cnt_r <= 4'd0;
    end else if (state_r == IDLE) begin
      div_cnt_r  <= {DIV_W{1'b0}};
      tick_cnt_r <= 4'd0;
    end else if (tick_s) begin
      div_cnt_r  <= {DIV_W{1'b0}};
      tick_cnt_r <= tick_cnt_r + 4'd1;
    end else begin
      div_cnt_r  <= div_cnt_r + DIV_W'(1);
    end
  end

  // Capture mid-bit samples at tick 8 (and tick 7 for the majority vote).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      samp8_r <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
      samp7_r <= 1'b1;
`endif
    end else begin
      if (tick_s && (tick_cnt_r == 4'd7)) begin
        samp8_r <= rx_sync_r;
      end
`ifdef UART_RX_MAJORITY_EN
      if (tick_s && (tick_cnt_r == 4'd6)) begin
        samp7_r <= rx_sync_r;
      end
`endif
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic and end-of-frame strobe.
  always_comb begin
    next_state_s = state_r;
    frame_done_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_edge_s) next_state_s = START;
        else              next_state_s = IDLE;
      end
      START: begin
        if (decide_s) begin
          if (bit_s) next_state_s = IDLE;   // false start
          else       next_state_s = DATA;
        end else begin
          next_state_s = START;
        end
      end
      DATA: begin
        if (decide_s && (bit_cnt_r == LAST_DATA)) begin
          if (PARITY_BIT != 0) next_state_s = PARITY;
          else                 next_state_s = STOP;
        end else begin
          next_state_s = DATA;
        end
      end
      PARITY: begin
        if (decide_s) next_state_s = STOP;
        else          next_state_s = PARITY;
      end
      STOP: begin
        // Leaving at mid-stop lets a back-to-back start edge be seen.
        if (decide_s && (bit_cnt_r == LAST_STOP)) begin
          next_state_s = IDLE;
          frame_done_s = 1'b1;
        end else begin
          next_state_s = STOP;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Frame datapath: bit counter, shift register and pending error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt_r  <= 4'd0;
      shift_r    <= {DATA_LEN{1'b0}};
      par_bad_r  <= 1'b0;
      stop_bad_r <= 1'b0;
    end else begin
      if (next_state_s != state_r) begin
        bit_cnt_r <= 4'd0;
      end else if (decide_s) begin
        bit_cnt_r <= bit_cnt_r + 4'd1;
      end
      if (start_edge_s) begin
        shift_r <= {DATA_LEN{1'b0}};
      end else if ((state_r == DATA) && decide_s) begin
        shift_r <= {bit_s, shift_r[DATA_LEN-1:1]};
      end
      if (start_edge_s) begin
        par_bad_r <= 1'b0;
      end else if ((state_r == PARITY) && decide_s) begin
        par_bad_r <= par_bad_f(shift_r, bit_s);
      end
      if (start_edge_s) begin
        stop_bad_r <= 1'b0;
      end else if ((state_r == STOP) && decide_s && !bit_s) begin
        stop_bad_r <= 1'b1;
      end
    end
  end

  // Registered outputs; the final stop sample is folded straight into frame_err.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out   <= {DATA_LEN{1'b0}};
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= frame_done_s;
      busy       <= (next_state_s != IDLE);
      if (frame_done_s) begin
        data_out   <= shift_r;
        parity_err <= par_bad_r;
        frame_err  <= stop_bad_r | ~bit_s;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx - self-checking bench for uart_rx.
//   Three receivers share clk/rst: 8N1 (ch0), 8E1 (ch1) and 8N2 (ch2).
//   The line format is 160 clk per bit with OS_DIV=10.
//   A monitor logs every data_valid pulse. After each frame, the log is compared
//   against the word, parity and stop values that the bench itself drove.
module tb_uart_rx;
  localparam int CLK_FREQ = 1_536_000;
  localparam int BAUD     = 9600;
  localparam int BIT_CLK  = 160;

  logic clk = 1'b0;
  logic rst;
  logic rx0, rx1, rx2;
  logic [7:0] do0, do1, do2;
  logic dv0, dv1, dv2, pe0, pe1, pe2, fe0, fe1, fe2, bz0, bz1, bz2;
  logic [31:0] cyc = 32'd0;
  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0]  ch;
    logic [7:0]  d;
    logic        pe;
    logic        fe;
    logic [31:0] cyc;
  } ev_t;
  ev_t evq[$];

  always #5 clk = ~clk;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .PARITY_BIT(0), .DATA_LEN(8), .STOP_BIT(1)) u_n1 (
    .clk(clk), .rst(rst), .rx(rx0), .data_out(do0), .data_valid(dv0),
    .parity_err(pe0), .frame_err(fe0), .busy(bz0));
  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .PARITY_BIT(2), .DATA_LEN(8), .STOP_BIT(1)) u_e1 (
    .clk(clk), .rst(rst), .rx(rx1), .data_out(do1), .data_valid(dv1),
    .parity_err(pe1), .frame_err(fe1), .busy(bz1));
  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .PARITY_BIT(0), .DATA_LEN(8), .STOP_BIT(2)) u_n2 (
    .clk(clk), .rst(rst), .rx(rx2), .data_out(do2), .data_valid(dv2),
    .parity_err(pe2), .frame_err(fe2), .busy(bz2));

  always @(posedge clk) cyc <= cyc + 32'd1;

  // Log every data_valid cycle, sampled away from the active edge.
  always @(negedge clk) begin
    if (dv0) evq.push_back('{ch: 2'd0, d: do0, pe: pe0, fe: fe0, cyc: cyc});
    if (dv1) evq.push_back('{ch: 2'd1, d: do1, pe: pe1, fe: fe1, cyc: cyc});
    if (dv2) evq.push_back('{ch: 2'd2, d: do2, pe: pe2, fe: fe2, cyc: cyc});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_rx(input int ch, input logic v);
    case (ch)
      0:       rx0 = v;
      1:       rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  function automatic logic busy_of(input int ch);
    case (ch)
      0:       return bz0;
      1:       return bz1;
      default: return bz2;
    endcase
  endfunction

  function automatic logic [11:0] outs_of(input int ch);
    case (ch)
      0:       return {do0, dv0, pe0, fe0, bz0};
      1:       return {do1, dv1, pe1, fe1, bz1};
      default: return {do2, dv2, pe2, fe2, bz2};
    endcase
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one 8-bit frame; glitch >= 0 puts a 1-clk high pulse that many clk into bit 0.
  task automatic send_frame(input int ch, input logic [7:0] d, input logic par_en, input logic p,
                            input int nstop, input logic [1:0] stop_v, input int gap, input int glitch);
    set_rx(ch, 1'b0);
    wait_clk(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      set_rx(ch, d[i]);
      if (i == 0 && glitch >= 0) begin
        wait_clk(glitch);
        set_rx(ch, 1'b1);
        wait_clk(1);
        set_rx(ch, d[0]);
        wait_clk(BIT_CLK - glitch - 1);
      end else begin
        wait_clk(BIT_CLK);
      end
    end
    if (par_en) begin
      set_rx(ch, p);
      wait_clk(BIT_CLK);
    end
    for (int s = 0; s < nstop; s++) begin
      set_rx(ch, stop_v[s]);
      wait_clk(BIT_CLK);
    end
    set_rx(ch, 1'b1);
    wait_clk(gap);
  endtask

  task automatic expect_frame(input string tag, input int ch, input logic [7:0] d,
                              input logic pe, input logic fe);
    ev_t e;
    check({tag, "_count"}, evq.size(), 32'd1);
    if (evq.size() > 0) begin
      e = evq.pop_front();
      check({tag, "_ch"}, {30'd0, e.ch}, ch);
      check({tag, "_data"}, {24'd0, e.d}, {24'd0, d});
      check({tag, "_perr"}, {31'd0, e.pe}, {31'd0, pe});
      check({tag, "_ferr"}, {31'd0, e.fe}, {31'd0, fe});
    end
    check({tag, "_busy"}, {31'd0, busy_of(ch)}, 32'd0);
    evq.delete();
  endtask

  initial begin
    ev_t e0, e1;
    int glitch;
    int ch, nstop, gap;
    logic [7:0] d;
    logic [1:0] stop_v;
    logic p, exp_pe, exp_fe;

    rst = 1'b0;
    rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
    wait_clk(5);
    for (int c = 0; c < 3; c++) check($sformatf("reset_ch%0d", c), {20'd0, outs_of(c)}, 32'd0);
    rst = 1'b1;
    wait_clk(20);
    evq.delete();

    // 1: 8N1 0xA5
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1, 2'b11, 40, -1);
    expect_frame("t1", 0, 8'hA5, 1'b0, 1'b0);

    // 2: even parity, wrong then right parity bit
    send_frame(1, 8'h3C, 1'b1, 1'b1, 1, 2'b11, 40, -1);
    expect_frame("t2_bad", 1, 8'h3C, 1'b1, 1'b0);
    send_frame(1, 8'h3C, 1'b1, 1'b0, 1, 2'b11, 40, -1);
    expect_frame("t2_good", 1, 8'h3C, 1'b0, 1'b0);

    // 3: stop bit driven low, one idle bit, then a clean frame
    send_frame(0, 8'h81, 1'b0, 1'b0, 1, 2'b10, BIT_CLK, -1);
    expect_frame("t3_ferr", 0, 8'h81, 1'b0, 1'b1);
    send_frame(0, 8'h55, 1'b0, 1'b0, 1, 2'b11, 40, -1);
    expect_frame("t3_clean", 0, 8'h55, 1'b0, 1'b0);

    // 4: 40-clk low pulse is a false start
    set_rx(0, 1'b0);
    wait_clk(40);
    set_rx(0, 1'b1);
    check("t4_busy_hi", {31'd0, bz0}, 32'd1);
    wait_clk(200);
    check("t4_busy_lo", {31'd0, bz0}, 32'd0);
    check("t4_no_valid", evq.size(), 32'd0);
    send_frame(0, 8'h12, 1'b0, 1'b0, 1, 2'b11, 40, -1);
    expect_frame("t4_next", 0, 8'h12, 1'b0, 1'b0);

    // 5: reset in the middle of data bit 4 of 0xF0
    d = 8'hF0;
    set_rx(0, 1'b0);
    wait_clk(BIT_CLK);
    for (int i = 0; i < 4; i++) begin
      set_rx(0, d[i]);
      wait_clk(BIT_CLK);
    end
    set_rx(0, d[4]);
    wait_clk(80);
    rst = 1'b0;
    #1;
    check("t5_rst_outs", {20'd0, outs_of(0)}, 32'd0);
    wait_clk(3);
    set_rx(0, 1'b1);
    wait_clk(3);
    rst = 1'b1;
    wait_clk(BIT_CLK);
    check("t5_no_valid", evq.size(), 32'd0);
    send_frame(0, 8'h0F, 1'b0, 1'b0, 1, 2'b11, 40, -1);
    expect_frame("t5_next", 0, 8'h0F, 1'b0, 1'b0);

    // 6: two stop bits, back-to-back 0x00 / 0xFF
`ifdef UART_RX_MAJORITY_EN
    glitch = 80;
`else
    glitch = -1;
`endif
    evq.delete();
    send_frame(2, 8'h00, 1'b0, 1'b0, 2, 2'b11, 0, glitch);
    send_frame(2, 8'hFF, 1'b0, 1'b0, 2, 2'b11, 40, -1);
    check("t6_count", evq.size(), 32'd2);
    if (evq.size() == 2) begin
      e0 = evq.pop_front();
      e1 = evq.pop_front();
      check("t6_d0", {24'd0, e0.d}, 32'h00);
      check("t6_d1", {24'd0, e1.d}, 32'hFF);
      check("t6_err0", {30'd0, e0.pe, e0.fe}, 32'd0);
      check("t6_err1", {30'd0, e1.pe, e1.fe}, 32'd0);
      check("t6_gap", e1.cyc - e0.cyc, 32'd1760);
    end
    evq.delete();

    // Random frames on random receivers, with occasional parity and stop faults.
    for (int k = 0; k < 12; k++) begin
      ch     = $urandom_range(0, 2);
      d      = 8'($urandom);
      p      = (^d) ^ ($urandom_range(0, 2) == 0);
      stop_v = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b11;
      gap    = $urandom_range(BIT_CLK, 2 * BIT_CLK);
      nstop  = (ch == 2) ? 2 : 1;
      exp_pe = (ch == 1) ? (((^d) ^ p) != 1'b0) : 1'b0;
      exp_fe = (ch == 2) ? !(stop_v[0] && stop_v[1]) : !stop_v[0];
      send_frame(ch, d, ch == 1, p, nstop, stop_v, gap, -1);
      expect_frame($sformatf("rnd%0d", k), ch, d, exp_pe, exp_fe);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
